// File: rtl/mem_pkg.sv
// Shared sizing and types for the MEM-stage data memory.
// Optional build macro: MEM_WR_FORWARD_EN (see mem_unit).
package mem_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int MEM_AW = 12;
   localparam int DEPTH  = 2 ** MEM_AW;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [MEM_AW-1:0] index_t;

   // Where the registered read result currently comes from.
   typedef enum logic [1:0] {
      SRC_ZERO  = 2'd0,
      SRC_ARRAY = 2'd1,
      SRC_FWD   = 2'd2
   } rdSrc_t;

   // Upper address bits must be clear for the word to exist in the array.
   function automatic logic inRange(input addr_t a);
      return a[ADDR_W-1:MEM_AW] == '0;
   endfunction
endpackage

// File: rtl/mem_if.sv
// Request/response bundle between the datapath MEM stage and the data memory.
interface mem_if;
   import mem_pkg::*;

   logic  memRead;
   logic  memWrite;
   addr_t addr;
   word_t din;
   word_t dataOut;

   modport master (output memRead, output memWrite, output addr, output din, input dataOut);
   modport slave  (input memRead, input memWrite, input addr, input din, output dataOut);
endinterface

// File: rtl/mem_array.sv
// Raw DEPTH x DATA_W storage: one write port and one synchronous read port
// sharing a single index. A simultaneous read and write returns the old word.
module mem_array
   import mem_pkg::*;
(
   input  logic   clk,
   input  logic   we,
   input  logic   re,
   input  index_t idx,
   input  word_t  wrData,
   output word_t  rdData
);
   word_t mem [DEPTH];

   // Write lands at the edge; read captures the pre-write contents.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wrData;
      if (re) rdData   <= mem[idx];
   end
endmodule

// File: rtl/mem_unit.sv
// MEM-stage data memory: adds reset, address range check, optional
// write-to-read forwarding and the held read result around mem_array.
// Build macro MEM_WR_FORWARD_EN: a same-address read+write returns din
// (write-first); without it the old contents are returned.
module mem_unit
   import mem_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   mem_if.slave  bus
);
   logic   okAddr;
   logic   wrEn;
   logic   rdEn;
   logic   fwdHit;
   logic   arrRe;
   word_t  arrData;
   word_t  fwdData;
   rdSrc_t rdSrc;

   assign okAddr = inRange(bus.addr);
   // Requests sampled during reset are dropped entirely.
   assign wrEn   = bus.memWrite & ~rst & okAddr;
   assign rdEn   = bus.memRead  & ~rst & okAddr;
`ifdef MEM_WR_FORWARD_EN
   assign fwdHit = rdEn & wrEn;
`else
   assign fwdHit = 1'b0;
`endif
   // The array only updates its read register on a real array read, so it
   // holds the last array word while idle or while another source is selected.
   assign arrRe  = rdEn & ~fwdHit;

   mem_array uArray (
      .clk    (clk),
      .we     (wrEn),
      .re     (arrRe),
      .idx    (bus.addr[MEM_AW-1:0]),
      .wrData (bus.din),
      .rdData (arrData)
   );

   // Track the source of the held read value; a non-read cycle keeps it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdSrc <= SRC_ZERO;
      end else if (bus.memRead) begin
         if (!okAddr) begin
            rdSrc <= SRC_ZERO;
         end else if (fwdHit) begin
            rdSrc   <= SRC_FWD;
            fwdData <= bus.din;
         end else begin
            rdSrc <= SRC_ARRAY;
         end
      end
   end

   // Output select between registered sources only, so dataOut is glitch-free
   // relative to the inputs and changes only at the clock edge.
   always_comb begin
      bus.dataOut = '0;
      case (rdSrc)
         SRC_ARRAY: bus.dataOut = arrData;
         SRC_FWD:   bus.dataOut = fwdData;
         default:   bus.dataOut = '0;
      endcase
   end
endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: the driver queues the expected dataOut for
// each checked cycle, the monitor compares after the edge.
module tb_mem_unit;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst;
   mem_if bus ();

   mem_unit dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   word_t expQ [$];
   string nameQ [$];
   logic  chkReq = 1'b0;
   int    checks = 0;
   int    errors = 0;

`ifdef MEM_WR_FORWARD_EN
   localparam word_t SAME_ADDR_EXP = 16'h2222;
`else
   localparam word_t SAME_ADDR_EXP = 16'h1111;
`endif

   // Apply one cycle of stimulus at the falling edge; optionally queue the
   // value dataOut must show after the next rising edge.
   task automatic cyc(input logic r, input logic rd, input logic wr,
                      input addr_t a, input word_t d,
                      input logic chk, input word_t exp, input string nm);
      @(negedge clk);
      rst          = r;
      bus.memRead  = rd;
      bus.memWrite = wr;
      bus.addr     = a;
      bus.din      = d;
      chkReq       = chk;
      if (chk) begin
         expQ.push_back(exp);
         nameQ.push_back(nm);
      end
   endtask

   // Monitor: every rising edge with a pending request is compared 1ns later.
   always @(posedge clk) begin
      logic doChk;
      word_t e;
      string n;
      doChk = chkReq;
      #1;
      if (doChk) begin
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow got=%h", bus.dataOut);
         end else begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checks++;
            if (bus.dataOut !== e) begin
               errors++;
               $display("FAIL %s dataOut=%h expected=%h", n, bus.dataOut, e);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.addr = '0; bus.din = '0;
      // reset and idle
      cyc(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, "reset0");
      cyc(1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, "reset1");
      cyc(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, "idle0");
      cyc(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, "idle1");
      // basic write / read
      cyc(0, 0, 1, 16'h0AAA, 16'h0FFF, 1, 16'h0000, "wr_no_read");
      cyc(0, 1, 0, 16'h0AAA, 16'h0000, 1, 16'h0FFF, "rd_0AAA");
      // no enables: nothing written, output held
      cyc(0, 0, 0, 16'h0DDD, 16'h0CCC, 1, 16'h0FFF, "hold_noen");
      cyc(0, 0, 1, 16'h0DDD, 16'h1234, 1, 16'h0FFF, "hold_on_wr");
      cyc(0, 1, 0, 16'h0DDD, 16'h0000, 1, 16'h1234, "rd_0DDD");
      cyc(0, 1, 0, 16'h0AAA, 16'h0000, 1, 16'h0FFF, "rd_0AAA_b");
      // reset pulse with a read pending: dropped, contents kept
      cyc(1, 1, 0, 16'h0AAA, 16'h0000, 1, 16'h0000, "rd_in_reset");
      cyc(0, 1, 0, 16'h0AAA, 16'h0000, 1, 16'h0FFF, "rd_after_reset");
      // write during reset is dropped
      cyc(1, 0, 1, 16'h0AAA, 16'h9999, 1, 16'h0000, "wr_in_reset");
      cyc(0, 1, 0, 16'h0AAA, 16'h0000, 1, 16'h0FFF, "wr_in_reset_kept");
      // same-address read+write
      cyc(0, 0, 1, 16'h0010, 16'h1111, 1, 16'h0FFF, "wr_0010");
      cyc(0, 1, 1, 16'h0010, 16'h2222, 1, SAME_ADDR_EXP, "rw_same");
      cyc(0, 1, 0, 16'h0010, 16'h0000, 1, 16'h2222, "rd_after_rw");
      // out-of-range write ignored, read returns zero, no aliasing
      cyc(0, 0, 1, 16'h1AAA, 16'hBEEF, 1, 16'h2222, "oor_wr");
      cyc(0, 1, 0, 16'h1AAA, 16'h0000, 1, 16'h0000, "oor_rd");
      cyc(0, 1, 0, 16'h0AAA, 16'h0000, 1, 16'h0FFF, "oor_no_alias");
      // out-of-range read+write never forwards
      cyc(0, 1, 1, 16'hFAAA, 16'h7777, 1, 16'h0000, "oor_rw");
      cyc(0, 1, 0, 16'h0AAA, 16'h0000, 1, 16'h0FFF, "oor_rw_no_alias");
      // top in-range word
      cyc(0, 0, 1, 16'h0FFF, 16'hA5A5, 1, 16'h0FFF, "wr_top");
      cyc(0, 1, 0, 16'h0FFF, 16'h0000, 1, 16'hA5A5, "rd_top");
      cyc(0, 1, 0, 16'h1000, 16'h0000, 1, 16'h0000, "rd_first_oor");
      // hold after an out-of-range read stays zero
      cyc(0, 0, 0, 16'h0FFF, 16'h0000, 1, 16'h0000, "hold_zero");
      cyc(0, 1, 0, 16'h0DDD, 16'h0000, 1, 16'h1234, "rd_0DDD_b");
      cyc(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, "");
      repeat (3) @(negedge clk);
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d expected=0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
